// File: rtl/muxn_rr_reg.sv
// N:1 multiplexer with a registered output and valid/ready on every port.
// Channels are picked either by direct select or by round-robin arbitration.
module muxn_rr_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] src_p1;
  logic             vld_p1;
  logic             err_p1;
  logic [SEL_W-1:0] rr_ptr;

  logic             ld_p0;
  logic             sel_ok_p0;
  logic [SEL_W:0]   rr_hit_p0;
  logic             grant_p0;
  logic [SEL_W-1:0] g_p0;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;
  logic             xfer_p0;
  logic [SEL_W-1:0] rr_nxt_p0;

  // Returns {found, index} of the first valid channel scanning from ptr
  // upwards with wrap; the reverse loop lets the closest channel win.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_IN-1:0] vld,
                                             input logic [SEL_W-1:0]  ptr);
    logic [SEL_W:0] pick;
    logic [SEL_W:0] idx;
    pick = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx >= NUM_IN_W) idx = idx - NUM_IN_W;
      for (int c = 0; c < NUM_IN; c++) begin
        if (vld[c] && ((SEL_W+1)'(c) == idx)) pick = {1'b1, idx[SEL_W-1:0]};
      end
    end
    return pick;
  endfunction

  // Stage p0: grant selection, handshake and input mux
  always_comb begin
    ld_p0     = ~vld_p1 | out_ready;
    sel_ok_p0 = ({1'b0, sel} < NUM_IN_W);
    rr_hit_p0 = rr_pick(in_valid, rr_ptr);
    if (mode) begin
      grant_p0 = rr_hit_p0[SEL_W];
      g_p0     = rr_hit_p0[SEL_W-1:0];
    end else begin
      // Direct mode offers ready without looking at the selected valid.
      grant_p0 = sel_ok_p0;
      g_p0     = sel;
    end
  end

  always_comb begin
    vld_p0   = 1'b0;
    data_p0  = '0;
    in_ready = '0;
    for (int c = 0; c < NUM_IN; c++) begin
      if (SEL_W'(c) == g_p0) begin
        vld_p0  = in_valid[c];
        data_p0 = in_data[c*WIDTH +: WIDTH];
      end
      in_ready[c] = ~rst & ld_p0 & grant_p0 & (SEL_W'(c) == g_p0);
    end
    xfer_p0   = ~rst & ld_p0 & grant_p0 & vld_p0;
    rr_nxt_p0 = (g_p0 == LAST_CH) ? '0 : g_p0 + SEL_W'(1);
  end

  // Stage p1: output register, round-robin pointer and select error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      src_p1  <= '0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      err_p1 <= ~mode & ~sel_ok_p0;
      if (ld_p0) begin
        if (xfer_p0) begin
          data_p1 <= data_p0;
          src_p1  <= g_p0;
          vld_p1  <= 1'b1;
          if (mode) rr_ptr <= rr_nxt_p0;
        end else begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  assign out_data  = data_p1;
  assign out_src   = src_p1;
  assign out_valid = vld_p1;
  assign sel_err   = err_p1;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Scoreboard bench for muxn_rr_reg: directed stimulus queues expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_muxn_rr_reg;

  localparam int W = 16;
  localparam int N = 8;
  localparam int S = 3;
  localparam int N5 = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [S-1:0]   sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;

  logic            mode5;
  logic [S-1:0]    sel5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_valid5;
  logic [N5-1:0]   in_ready5;
  logic [W-1:0]    out_data5;
  logic [S-1:0]    out_src5;
  logic            out_valid5;
  logic            out_ready5;
  logic            sel_err5;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic [S-1:0] s;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   rr_seq [10] = '{2, 4, 7, 2, 4, 7, 2, 7, 2, 7};

  muxn_rr_reg #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  muxn_rr_reg #(.WIDTH(W), .NUM_IN(N5), .SEL_W(S)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_src(out_src5), .out_valid(out_valid5),
    .out_ready(out_ready5), .sel_err(sel_err5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [S-1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual src=%0d data=%h required=no beat", out_src, out_data);
      end else begin
        mon_e = q.pop_front();
        chk("beat_data", 32'(out_data), 32'(mon_e.d));
        chk("beat_src", 32'(out_src), 32'(mon_e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1; in_valid = '1;
    for (int c = 0; c < N; c++) in_data[c*W +: W] = 16'(32'hA000 + c);
    mode5 = 1'b0; sel5 = '0; out_ready5 = 1'b1; in_valid5 = '1;
    for (int c = 0; c < N5; c++) in_data5[c*W +: W] = 16'(32'hC000 + c);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    tick();
    rst = 1'b0;

    // Direct-select sweep
    for (int s = 0; s < N; s++) begin
      sel = S'(s);
      push(16'(32'hA000 + s), S'(s));
      @(negedge clk);
      chk("sweep_in_ready", 32'(in_ready), 32'(1 << s));
      tick();
    end

    // Backpressure on channel 3
    sel = 3'd3;
    push(16'hA003, 3'd3);
    tick();
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'hA003);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    in_data[3*W +: W] = 16'hB003;
    push(16'hB003, 3'd3);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'h08);
    tick();
    in_data[3*W +: W] = 16'hA003;

    // Round-robin with channel 4 dropping out mid-run
    mode = 1'b1;
    in_valid = 8'b1001_0100;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) in_valid = 8'b1000_0100;
      push(16'(32'hA000 + rr_seq[i]), S'(rr_seq[i]));
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(1 << rr_seq[i]));
      tick();
    end

    // Selected channel idle: ready still offered, output empties
    mode = 1'b0;
    sel = 3'd7;
    in_valid = 8'b0111_1111;
    @(negedge clk);
    chk("nogrant_in_ready", 32'(in_ready), 32'h80);
    tick();
    @(negedge clk);
    chk("nogrant_out_valid", 32'(out_valid), 32'h0);
    chk("nogrant_out_data_hold", 32'(out_data), 32'hA007);
    chk("nogrant_out_src_hold", 32'(out_src), 32'h7);
    chk("nogrant_sel_err", 32'(sel_err), 32'h0);

    // Out-of-range select on the five-channel build
    tick();
    sel5 = 3'd6;
    @(negedge clk);
    chk("n5_bad_sel_in_ready", 32'(in_ready5), 32'h0);
    tick();
    sel5 = 3'd1;
    @(negedge clk);
    chk("n5_sel_err", 32'(sel_err5), 32'h1);
    chk("n5_bad_sel_out_valid", 32'(out_valid5), 32'h0);
    tick();
    @(negedge clk);
    chk("n5_sel_err_clear", 32'(sel_err5), 32'h0);
    chk("n5_out_valid", 32'(out_valid5), 32'h1);
    chk("n5_out_src", 32'(out_src5), 32'h1);
    chk("n5_out_data", 32'(out_data5), 32'hC001);

    // Park the pointer at 5, detour through direct mode, then resume
    tick();
    mode = 1'b1;
    in_valid = 8'b0001_0000;
    push(16'hA004, 3'd4);
    tick();
    mode = 1'b0;
    in_valid = '1;
    for (int s = 1; s <= 3; s++) begin
      sel = S'(s);
      push(16'(32'hA000 + s), S'(s));
      tick();
    end
    mode = 1'b1;
    push(16'hA005, 3'd5);
    @(negedge clk);
    chk("resume_in_ready", 32'(in_ready), 32'h20);
    tick();
    push(16'hA006, 3'd6);
    tick();

    // Reset while a stalled word is held
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'h0);
    chk("rst_hold_out_valid", 32'(out_valid), 32'h1);
    tick();
    if (q.size() > 0) void'(q.pop_back());
    @(negedge clk);
    chk("rst_drop_out_valid", 32'(out_valid), 32'h0);
    chk("rst_drop_out_data", 32'(out_data), 32'h0);
    chk("rst_drop_out_src", 32'(out_src), 32'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = '0;
    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
